// File: rtl/thermometer_encoder_if.sv
// Bus bundle for the binary-to-thermometer encoder: binary input side plus
// the combinational and registered unary outputs.
interface thermometer_encoder_if #(
    parameter int WIDTH = 3
);
    localparam int N = (2 ** WIDTH) - 1;

    logic [WIDTH-1:0] value;
    logic             in_valid;
    logic [N-1:0]     therm;
    logic [N-1:0]     therm_q;
    logic             out_valid;
    logic [WIDTH-1:0] count_q;

    modport master (
        output value,
        output in_valid,
        input  therm,
        input  therm_q,
        input  out_valid,
        input  count_q
    );

    modport slave (
        input  value,
        input  in_valid,
        output therm,
        output therm_q,
        output out_valid,
        output count_q
    );
endinterface

// File: rtl/thermometer_encoder.sv
// Binary-to-thermometer encoder: zero-latency unary code plus a one-cycle
// registered copy with its binary count and a valid flag.
module thermometer_encoder #(
    parameter int WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    thermometer_encoder_if.slave  bus
);
    localparam int N = (2 ** WIDTH) - 1;

    logic [N-1:0] therm_code;

    // Bit i is set exactly when i is below the unsigned input value.
    always_comb begin
        therm_code = '0;
        for (int i = 0; i < N; i++) begin
            therm_code[i] = (32'(i) < 32'(bus.value));
        end
    end

    assign bus.therm = therm_code;

    logic [N-1:0]     therm_r;
    logic [WIDTH-1:0] count_r;
    logic             valid_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            therm_r <= '0;
            count_r <= '0;
            valid_r <= 1'b0;
        end else if (bus.in_valid) begin
            therm_r <= therm_code;
            count_r <= bus.value;
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign bus.therm_q   = therm_r;
    assign bus.count_q   = count_r;
    assign bus.out_valid = valid_r;
endmodule

// File: tb/tb_thermometer_encoder.sv
// Directed self-checking bench for thermometer_encoder (WIDTH = 3, N = 7).
module tb_thermometer_encoder;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    thermometer_encoder_if #(.WIDTH(3)) bus ();

    thermometer_encoder #(.WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] sweep_table [8];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] v, input logic valid);
        bus.value    = v;
        bus.in_valid = valid;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        sweep_table[0] = 7'b0000000;
        sweep_table[1] = 7'b0000001;
        sweep_table[2] = 7'b0000011;
        sweep_table[3] = 7'b0000111;
        sweep_table[4] = 7'b0001111;
        sweep_table[5] = 7'b0011111;
        sweep_table[6] = 7'b0111111;
        sweep_table[7] = 7'b1111111;

        rst_n = 1'b0;
        applyStimulus(3'd0, 1'b0);
        #12;
        checkOutput("reset_therm_q", 32'(bus.therm_q), 32'd0);
        checkOutput("reset_count_q", 32'(bus.count_q), 32'd0);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational sweep with 10 units of settle per value
        for (int v = 0; v < 8; v++) begin
            applyStimulus(3'(v), 1'b0);
            #10;
            checkOutput($sformatf("sweep_%0d", v), 32'(bus.therm), 32'(sweep_table[v]));
        end

        @(negedge clk);
        applyStimulus(3'd5, 1'b1);
        nextEdge();
        checkOutput("cap5_therm_q", 32'(bus.therm_q), 32'b0011111);
        checkOutput("cap5_count_q", 32'(bus.count_q), 32'd5);
        checkOutput("cap5_out_valid", 32'(bus.out_valid), 32'd1);

        applyStimulus(3'd2, 1'b0);
        #1;
        checkOutput("hold_therm_now", 32'(bus.therm), 32'b0000011);
        nextEdge();
        checkOutput("hold_therm_q", 32'(bus.therm_q), 32'b0011111);
        checkOutput("hold_count_q", 32'(bus.count_q), 32'd5);
        checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd0);

        applyStimulus(3'd7, 1'b1);
        nextEdge();
        checkOutput("cap7_therm_q", 32'(bus.therm_q), 32'b1111111);
        checkOutput("cap7_count_q", 32'(bus.count_q), 32'd7);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_therm_q", 32'(bus.therm_q), 32'd0);
        checkOutput("areset_count_q", 32'(bus.count_q), 32'd0);
        checkOutput("areset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("areset_therm", 32'(bus.therm), 32'b1111111);
        @(negedge clk);
        checkOutput("areset_held_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;

        // Back-to-back captures: 7, 0, 7
        nextEdge();
        checkOutput("b2b0_therm_q", 32'(bus.therm_q), 32'b1111111);
        checkOutput("b2b0_out_valid", 32'(bus.out_valid), 32'd1);
        applyStimulus(3'd0, 1'b1);
        nextEdge();
        checkOutput("b2b1_therm_q", 32'(bus.therm_q), 32'b0000000);
        checkOutput("b2b1_count_q", 32'(bus.count_q), 32'd0);
        applyStimulus(3'd7, 1'b1);
        nextEdge();
        checkOutput("b2b2_therm_q", 32'(bus.therm_q), 32'b1111111);
        checkOutput("b2b2_count_q", 32'(bus.count_q), 32'd7);
        applyStimulus(3'd3, 1'b0);
        nextEdge();
        checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("idle_therm_q", 32'(bus.therm_q), 32'b1111111);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
